// File: rtl/contour_frame_sequencer_if.sv
// Shared edge-BRAM bus: write port A, read port B.
// master = sequencer side, slave = BRAM side.
interface contour_frame_sequencer_if #(
  parameter int ADDR_W = 19,
  parameter int BIN_W  = 3
);
  logic [ADDR_W-1:0] bram_addr_a;
  logic [BIN_W-1:0]  bram_din_a;
  logic              bram_we_a;
  logic [ADDR_W-1:0] bram_addr_b;
  logic [BIN_W-1:0]  bram_dout_b;

  modport master (
    output bram_addr_a,
    output bram_din_a,
    output bram_we_a,
    output bram_addr_b,
    input  bram_dout_b
  );

  modport slave (
    input  bram_addr_a,
    input  bram_din_a,
    input  bram_we_a,
    input  bram_addr_b,
    output bram_dout_b
  );
endinterface

// File: rtl/contour_frame_sequencer.sv
// Clear / fill / trace / display pass sequencer owning the edge BRAM.
// Optional CLEAR phase is compiled in with CONTOUR_CLEAR_EN.
module contour_frame_sequencer #(
  parameter int WIDTH          = 640,
  parameter int HEIGHT         = 480,
  parameter int ADDR_W         = 19,
  parameter int BIN_W          = 3,
  parameter int TIMEOUT_CYCLES = 2000000,
  parameter int DISPLAY_FRAMES = 60
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              go,
  input  logic              continuous,
  output logic              fill_start,
  input  logic              fill_done,
  input  logic [ADDR_W-1:0] fill_addr,
  input  logic [BIN_W-1:0]  fill_data,
  input  logic              fill_we,
  output logic              trace_start,
  input  logic              trace_done,
  input  logic [ADDR_W-1:0] trace_addr_read,
  input  logic [ADDR_W-1:0] trace_addr_write,
  input  logic [BIN_W-1:0]  trace_data,
  input  logic [ADDR_W-1:0] disp_addr,
  input  logic              vsync,
  contour_frame_sequencer_if.master bram,
  output logic [BIN_W-1:0]  rd_data,
  output logic              busy,
  output logic              pass_done,
  output logic              timeout_err,
  output logic [2:0]        state_o
);

  localparam int PIX  = WIDTH * HEIGHT;
  localparam int TO_W = $clog2(TIMEOUT_CYCLES + 1);
  localparam int FR_W = $clog2(DISPLAY_FRAMES + 1);

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_CLEAR = 3'd1,
    S_FILL  = 3'd2,
    S_TRACE = 3'd3,
    S_DISP  = 3'd4
  } state_t;

  state_t          state;
  logic [TO_W-1:0] to_cnt;
  logic [FR_W-1:0] fr_cnt;
  logic            vsync_q;
  logic            vs_rise;

`ifdef CONTOUR_CLEAR_EN
  localparam int CLR_W = $clog2(PIX + 1);
  logic [CLR_W-1:0] clear_addr;
`endif

  assign vs_rise     = vsync & ~vsync_q;
  assign fill_start  = (state == S_FILL);
  assign trace_start = (state == S_TRACE);
  assign busy        = (state != S_IDLE);
  assign state_o     = state;
  assign rd_data     = bram.bram_dout_b;

  // Pass FSM with phase counters and status flags.
  always_ff @(posedge clk) begin
    if (reset) begin
      state       <= S_IDLE;
      to_cnt      <= '0;
      fr_cnt      <= '0;
      vsync_q     <= 1'b0;
      pass_done   <= 1'b0;
      timeout_err <= 1'b0;
`ifdef CONTOUR_CLEAR_EN
      clear_addr  <= '0;
`endif
    end else begin
      vsync_q   <= vsync;
      pass_done <= 1'b0;
      unique case (state)
        S_IDLE: begin
          if (go) begin
`ifdef CONTOUR_CLEAR_EN
            state      <= S_CLEAR;
            clear_addr <= '0;
`else
            state      <= S_FILL;
`endif
          end
        end
`ifdef CONTOUR_CLEAR_EN
        S_CLEAR: begin
          if (clear_addr == CLR_W'(PIX - 1)) begin
            state      <= S_FILL;
            clear_addr <= '0;
          end else begin
            clear_addr <= clear_addr + 1'b1;
          end
        end
`endif
        S_FILL: begin
          if (fill_done) begin
            state  <= S_TRACE;
            to_cnt <= '0;
          end
        end
        S_TRACE: begin
          if (trace_done) begin
            state  <= S_DISP;
            fr_cnt <= '0;
          end else if (to_cnt == TO_W'(TIMEOUT_CYCLES - 1)) begin
            timeout_err <= 1'b1;
            state       <= S_DISP;
            fr_cnt      <= '0;
          end else begin
            to_cnt <= to_cnt + 1'b1;
          end
        end
        S_DISP: begin
          if (vs_rise) begin
            if (fr_cnt == FR_W'(DISPLAY_FRAMES - 1)) begin
              fr_cnt    <= '0;
              pass_done <= 1'b1;
              if (continuous) begin
`ifdef CONTOUR_CLEAR_EN
                state      <= S_CLEAR;
                clear_addr <= '0;
`else
                state      <= S_FILL;
`endif
              end else begin
                state <= S_IDLE;
              end
            end else begin
              fr_cnt <= fr_cnt + 1'b1;
            end
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end

  // BRAM port ownership follows the registered phase.
  always_comb begin
    bram.bram_addr_a = '0;
    bram.bram_din_a  = '0;
    bram.bram_we_a   = 1'b0;
    bram.bram_addr_b = '0;
    unique case (state)
`ifdef CONTOUR_CLEAR_EN
      S_CLEAR: begin
        bram.bram_addr_a = ADDR_W'(clear_addr);
        bram.bram_we_a   = 1'b1;
      end
`endif
      S_FILL: begin
        bram.bram_addr_a = fill_addr;
        bram.bram_din_a  = fill_data;
        bram.bram_we_a   = fill_we;
        bram.bram_addr_b = fill_addr;
      end
      S_TRACE: begin
        bram.bram_addr_a = trace_addr_write;
        bram.bram_din_a  = trace_data;
        bram.bram_we_a   = 1'b1;
        bram.bram_addr_b = trace_addr_read;
      end
      S_DISP: begin
        bram.bram_addr_b = disp_addr;
      end
      default: ;
    endcase
  end

endmodule

// File: tb/tb_contour_frame_sequencer.sv
// Scoreboard bench for contour_frame_sequencer.
// Small frame, short timeout and two-frame display.
module tb_contour_frame_sequencer;

  localparam int AW = 8;
  localparam int BW = 3;

  logic          clk = 1'b0;
  logic          reset, go, continuous;
  logic          fill_start, fill_done, fill_we;
  logic [AW-1:0] fill_addr;
  logic [BW-1:0] fill_data;
  logic          trace_start, trace_done;
  logic [AW-1:0] trace_addr_read, trace_addr_write, disp_addr;
  logic [BW-1:0] trace_data, rd_data;
  logic          vsync, busy, pass_done, timeout_err;
  logic [2:0]    state_o;

  contour_frame_sequencer_if #(.ADDR_W(AW), .BIN_W(BW)) bus ();

  contour_frame_sequencer #(
    .WIDTH(8), .HEIGHT(4), .ADDR_W(AW), .BIN_W(BW),
    .TIMEOUT_CYCLES(100), .DISPLAY_FRAMES(2)
  ) dut (
    .clk(clk), .reset(reset), .go(go), .continuous(continuous),
    .fill_start(fill_start), .fill_done(fill_done),
    .fill_addr(fill_addr), .fill_data(fill_data), .fill_we(fill_we),
    .trace_start(trace_start), .trace_done(trace_done),
    .trace_addr_read(trace_addr_read),
    .trace_addr_write(trace_addr_write),
    .trace_data(trace_data), .disp_addr(disp_addr), .vsync(vsync),
    .bram(bus.master), .rd_data(rd_data), .busy(busy),
    .pass_done(pass_done), .timeout_err(timeout_err),
    .state_o(state_o)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [2:0]    st;
    logic          fs;
    logic          ts;
    logic          bsy;
    logic          te;
    logic          pd;
    logic [AW-1:0] aa;
    logic [BW-1:0] da;
    logic          wa;
    logic [AW-1:0] ab;
    logic [BW-1:0] rd;
  } obs_t;

  obs_t  exp_q[$];
  string name_q[$];
  int    pass_q[$];
  int    checks = 0;
  int    errors = 0;

  function automatic string fmt(obs_t o);
    return $sformatf(
      "st=%0d fs=%0d ts=%0d busy=%0d te=%0d pd=%0d a=%0d din=%0d we=%0d b=%0d rd=%0d",
      o.st, o.fs, o.ts, o.bsy, o.te, o.pd, o.aa, o.da, o.wa, o.ab, o.rd);
  endfunction

  // Monitor: pops one expectation per cycle; checks every pass_done pulse.
  always @(negedge clk) begin
    obs_t  got, e;
    string n;
    got = '{state_o, fill_start, trace_start, busy, timeout_err,
            pass_done, bus.bram_addr_a, bus.bram_din_a, bus.bram_we_a,
            bus.bram_addr_b, rd_data};
    if (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      n = name_q.pop_front();
      checks++;
      if (got !== e) begin
        errors++;
        $display("FAIL %s: got %s expected %s", n, fmt(got), fmt(e));
      end
    end
    if (pass_done) begin
      checks++;
      if (pass_q.size() == 0) begin
        errors++;
        $display("FAIL pass_done: got 1 expected 0 (unexpected pulse)");
      end else begin
        void'(pass_q.pop_front());
      end
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(string n, logic [2:0] st, logic fs, logic ts,
                     logic bsy, logic te, logic pd, logic [AW-1:0] aa,
                     logic [BW-1:0] da, logic wa, logic [AW-1:0] ab,
                     logic [BW-1:0] rd);
    exp_q.push_back('{st, fs, ts, bsy, te, pd, aa, da, wa, ab, rd});
    name_q.push_back(n);
    @(negedge clk);
    #1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got no finish expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    reset = 1; go = 0; continuous = 0;
    fill_done = 0; fill_we = 0; fill_addr = '0; fill_data = '0;
    trace_done = 0; trace_addr_read = '0; trace_addr_write = '0;
    trace_data = '0; disp_addr = '0; vsync = 0;
    bus.bram_dout_b = 3'd5;
    repeat (2) step();
    chk("reset", 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 5);
    reset = 0;
    step();
    chk("idle", 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 5);

    go = 1;
    step();
    go = 0;
`ifdef CONTOUR_CLEAR_EN
    for (int i = 0; i < 32; i++) begin
      chk("clear", 1, 0, 0, 1, 0, 0, AW'(i), 0, 1, 0, 5);
      step();
    end
`endif
    fill_addr = 5; fill_data = 3; fill_we = 1; go = 1;
    chk("fill_wr", 2, 1, 0, 1, 0, 0, 5, 3, 1, 5, 5);
    step();
    go = 0;
    chk("fill_go_ignored", 2, 1, 0, 1, 0, 0, 5, 3, 1, 5, 5);
    fill_we = 0; fill_done = 1;
    step();
    fill_done = 0;
    trace_addr_write = 7; trace_data = 2; trace_addr_read = 9;
    bus.bram_dout_b = 3'd2;
    chk("trace_entry", 3, 0, 1, 1, 0, 0, 7, 2, 1, 9, 2);
    vsync = 1; disp_addr = 12;
    repeat (99) step();
    chk("trace_last", 3, 0, 1, 1, 0, 0, 7, 2, 1, 9, 2);
    step();
    chk("timeout", 4, 0, 0, 1, 1, 0, 0, 0, 0, 12, 2);
    step();
    chk("vsync_high_entry", 4, 0, 0, 1, 1, 0, 0, 0, 0, 12, 2);
    vsync = 0; step();
    vsync = 1; step();
    vsync = 0; step();
    chk("one_frame", 4, 0, 0, 1, 1, 0, 0, 0, 0, 12, 2);
    vsync = 1;
    pass_q.push_back(1);
    step();
    chk("pass_to_idle", 0, 0, 0, 0, 1, 1, 0, 0, 0, 0, 2);
    vsync = 0;
    step();
    chk("pass_pulse_end", 0, 0, 0, 0, 1, 0, 0, 0, 0, 0, 2);
    reset = 1;
    step();
    reset = 0;
    chk("reset_clears_te", 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 2);

    go = 1;
    step();
    go = 0;
`ifdef CONTOUR_CLEAR_EN
    repeat (32) step();
`endif
    chk("fill2", 2, 1, 0, 1, 0, 0, 5, 3, 0, 5, 2);
    fill_done = 1;
    step();
    fill_done = 0;
    repeat (99) step();
    trace_done = 1;
    chk("done_at_expiry", 3, 0, 1, 1, 0, 0, 7, 2, 1, 9, 2);
    step();
    trace_done = 0;
    chk("done_wins", 4, 0, 0, 1, 0, 0, 0, 0, 0, 12, 2);
    continuous = 1;
    vsync = 1; step();
    vsync = 0; step();
    vsync = 1;
    pass_q.push_back(1);
    step();
`ifdef CONTOUR_CLEAR_EN
    chk("continuous", 1, 0, 0, 1, 0, 1, 0, 0, 1, 0, 2);
`else
    chk("continuous", 2, 1, 0, 1, 0, 1, 5, 3, 0, 5, 2);
`endif
    vsync = 0;
`ifdef CONTOUR_CLEAR_EN
    repeat (32) step();
`endif
    fill_done = 1;
    step();
    fill_done = 0;
    chk("trace3", 3, 0, 1, 1, 0, 0, 7, 2, 1, 9, 2);
    reset = 1;
    step();
    chk("reset_mid_trace", 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 2);
    reset = 0;
    step();
    step();

    checks++;
    if (pass_q.size() != 0) begin
      errors++;
      $display("FAIL pass_pending: got %0d expected 0", pass_q.size());
    end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/contour_frame_sequencer.md
# contour_frame_sequencer

Sequences one contour-extraction pass over the shared 3-bit edge BRAM (WIDTH×HEIGHT words) and owns both of its ports. Each pass runs four phases in order:

1. Clear the BRAM.
2. Hand it to the edge-fill stage.
3. Hand it to the contour/color-bin tracer, with a level `start` held until `done`.
4. Hand it to the VGA display reader for a fixed number of frames.

The block sits between the top level and the BRAM, replacing ad-hoc muxing of the BRAM address and data lines.

## Interface
Parameters:
- WIDTH, 640, pixels per row
- HEIGHT, 480, rows
- ADDR_W, 19, BRAM address width
- BIN_W, 3, BRAM data width
- TIMEOUT_CYCLES, 2000000, max cycles allowed in TRACE
- DISPLAY_FRAMES, 60, vsync rising edges spent in DISPLAY

Ports:
- clk  in  1  system clock
- reset  in  1  synchronous, active-high
- go  in  1  pulse; starts a pass when IDLE
- continuous  in  1  sampled at end of DISPLAY; 1 = start next pass
- fill_start  out  1  level, high throughout FILL
- fill_done  in  1  fill stage finished
- fill_addr  in  ADDR_W  fill write address
- fill_data  in  BIN_W  fill write data
- fill_we  in  1  fill write enable
- trace_start  out  1  level, high throughout TRACE
- trace_done  in  1  tracer finished
- trace_addr_read  in  ADDR_W  tracer read address
- trace_addr_write  in  ADDR_W  tracer write address
- trace_data  in  BIN_W  tracer write data
- disp_addr  in  ADDR_W  display read address
- vsync  in  1  display vertical sync, active-high
- bram_addr_a  out  ADDR_W  write-port address
- bram_din_a  out  BIN_W  write-port data
- bram_we_a  out  1  write-port enable
- bram_addr_b  out  ADDR_W  read-port address
- bram_dout_b  in  BIN_W  read-port data
- rd_data  out  BIN_W  bram_dout_b forwarded to all requesters
- busy  out  1  state ≠ IDLE
- pass_done  out  1  one-cycle pulse at end of DISPLAY
- timeout_err  out  1  sticky; TRACE timed out
- state_o  out  3  current state, for debug

## Operation
States and transitions:
- IDLE (0): on go → CLEAR.
- CLEAR (1): clear_addr steps 0 → WIDTH*HEIGHT−1, one word per cycle. Port A drives addr = clear_addr, din = 0, we = 1. After the last word → FILL.
- FILL (2): fill_start = 1. Port A drives fill_addr / fill_data / fill_we. Port B drives fill_addr. On fill_done → TRACE.
- TRACE (3): trace_start = 1.
  - Port A drives trace_addr_write / trace_data with we = 1 every cycle; the tracer has no write enable and rewrites its current word.
  - Port B drives trace_addr_read.
  - A cycle counter is cleared on entry.
  - On trace_done → DISPLAY.
  - When the counter reaches TIMEOUT_CYCLES−1 without trace_done: set timeout_err, then → DISPLAY.
- DISPLAY (4): Port A we = 0. Port B drives disp_addr. Count vsync rising edges (vsync registered once to detect edges). On the DISPLAY_FRAMES-th edge:
  - pulse pass_done;
  - if continuous = 1 → CLEAR, else → IDLE.
- Outside TRACE, trace_start = 0. trace_start is therefore low for at least one cycle before every TRACE entry, which re-arms the tracer.
- Port muxes are combinational from the registered state. Unused ports drive addr = 0, din = 0, we = 0.
- go is ignored unless the state is IDLE.

## Timing
- Reset values: every output is 0, state = IDLE, all counters = 0, timeout_err cleared.
- Reset mid-pass: next cycle is IDLE. trace_start and fill_start drop immediately on that edge. Partially written BRAM contents are left as they are.
- go → first clear write: 1 cycle (state registers CLEAR on the go edge).
- CLEAR lasts exactly WIDTH*HEIGHT cycles.
- The mux adds no latency. The BRAM read latency (2 cycles) stays visible to requesters unchanged.
- trace_done and timeout in the same cycle: done wins, and timeout_err is not set.
- vsync already high on DISPLAY entry does not count as an edge.
- pass_done and the state change happen on the same edge.
- Counters are sized to hold WIDTH*HEIGHT and TIMEOUT_CYCLES respectively.

## Configuration
- CONTOUR_CLEAR_EN defined: the CLEAR state is compiled in, as described above.
- CONTOUR_CLEAR_EN undefined: there is no CLEAR state. IDLE on go, and DISPLAY with continuous = 1, both go directly to FILL. The fill stage is then responsible for overwriting every word.

## Test plan
- Run with WIDTH=8, HEIGHT=4, go pulse → exactly 32 cycles of we_a = 1, din = 0, addr 0..31. fill_start rises the cycle after addr 31.
- In FILL, drive fill_addr = 5, fill_data = 3, fill_we = 1 → bram_addr_a = 5, din = 3, we_a = 1. fill_done → trace_start = 1 the next cycle.
- Run with TIMEOUT_CYCLES=100 and no trace_done → timeout_err = 1 after 100 TRACE cycles, trace_start = 0, state_o = 4. A later reset clears timeout_err.
- Run with DISPLAY_FRAMES=2, continuous = 0 → pass_done pulses on the 2nd vsync rise, then IDLE, busy = 0. With continuous = 1 → CLEAR (or FILL when CONTOUR_CLEAR_EN is undefined).
- Assert reset during TRACE → next cycle state_o = 0, trace_start = 0, we_a = 0. A go pulse asserted during FILL has no effect.
- Assert trace_done on the same cycle the timeout count expires → DISPLAY with timeout_err = 0.
